// File: rtl/div_pkg.sv
// Shared types and constants for the divider request sequencer.
// Holds the FSM encoding, the request record and the conditional-negate helper.
package div_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [DIV_WIDTH-1:0] DBZ_QUOTIENT = {DIV_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        RUN   = 3'd2,
        FIN   = 3'd3,
        DRAIN = 3'd4,
        ZERO  = 3'd5
    } div_state_t;

    typedef struct packed {
        logic                 is_signed;
        logic [DIV_WIDTH-1:0] dividend;
        logic [DIV_WIDTH-1:0] divisor;
    } div_req_t;

    // Two's-complement negate when requested; the most negative value maps to itself.
    function automatic logic [DIV_WIDTH-1:0] cond_negate(
        input logic [DIV_WIDTH-1:0] value,
        input logic                 negate
    );
        logic [DIV_WIDTH-1:0] result;
        if (negate) begin
            result = ~value + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_req_fifo.sv
// Small synchronous request FIFO with full/empty flags.
// Pushes on full and pops on empty are ignored.
module div_req_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 33
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Request sequencer for the iterative restoring divider: queues requests, feeds
// magnitudes over the level Start/Done handshake and returns sign-corrected results.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             ReqValid,
    output logic             ReqReady,
    input  logic             ReqSigned,
    input  logic [WIDTH-1:0] ReqDividend,
    input  logic [WIDTH-1:0] ReqDivisor,
    output logic             DivStart,
    output logic [WIDTH-1:0] DivDividend,
    output logic [WIDTH-1:0] DivDivisor,
    input  logic [WIDTH-1:0] DivQuotient,
    input  logic [WIDTH-1:0] DivRemainder,
    input  logic             DivDone,
    output logic             RspValid,
    input  logic             RspReady,
    output logic [WIDTH-1:0] RspQuotient,
    output logic [WIDTH-1:0] RspRemainder,
    output logic             RspDivByZero,
    output logic             RspOverflow
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_r, state_s;
    div_req_t         fifo_in_s, fifo_head_s, req_r;
    logic             fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic             load_s, wr_div_s, wr_dbz_s, slot_free_s;
    logic             div_start_r, q_neg_r, r_neg_r, ovf_r;
    logic [WIDTH-1:0] div_dividend_r, div_divisor_r;
    logic             rsp_valid_r, rsp_dbz_r, rsp_ovf_r;
    logic [WIDTH-1:0] rsp_quotient_r, rsp_remainder_r;

    assign fifo_in_s   = '{is_signed: ReqSigned, dividend: ReqDividend, divisor: ReqDivisor};
    assign fifo_push_s = ReqValid && !fifo_full_s;
    assign ReqReady    = !fifo_full_s;
    assign slot_free_s = !rsp_valid_r || RspReady;

    div_req_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W ($bits(div_req_t))
    ) u_fifo (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .push      (fifo_push_s),
        .push_data (fifo_in_s),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // FSM state register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state and one-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        fifo_pop_s = 1'b0;
        load_s     = 1'b0;
        wr_div_s   = 1'b0;
        wr_dbz_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s = 1'b1;
                    state_s    = PREP;
                end else begin
                    state_s = IDLE;
                end
            end
            PREP: begin
                load_s = 1'b1;
                if (req_r.divisor == {DIV_WIDTH{1'b0}}) begin
                    state_s = ZERO;
                end else begin
                    state_s = RUN;
                end
            end
            RUN: begin
                if (DivDone) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN: begin
                if (slot_free_s) begin
                    wr_div_s = 1'b1;
                    state_s  = DRAIN;
                end else begin
                    state_s = FIN;
                end
            end
            // Done lingers one cycle after Start drops; restarting earlier would see it stale.
            DRAIN: begin
                if (!DivDone) begin
                    state_s = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            ZERO: begin
                if (slot_free_s) begin
                    wr_dbz_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = ZERO;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Captured request, operand magnitudes and sign-fix decisions.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            req_r          <= '0;
            div_dividend_r <= {WIDTH{1'b0}};
            div_divisor_r  <= {WIDTH{1'b0}};
            q_neg_r        <= 1'b0;
            r_neg_r        <= 1'b0;
            ovf_r          <= 1'b0;
        end else begin
            if (fifo_pop_s) begin
                req_r <= fifo_head_s;
            end
            if (load_s) begin
                div_dividend_r <= cond_negate(req_r.dividend, req_r.is_signed && req_r.dividend[WIDTH-1]);
                div_divisor_r  <= cond_negate(req_r.divisor, req_r.is_signed && req_r.divisor[WIDTH-1]);
                q_neg_r        <= req_r.is_signed && (req_r.dividend[WIDTH-1] ^ req_r.divisor[WIDTH-1]);
                r_neg_r        <= req_r.is_signed && req_r.dividend[WIDTH-1];
                ovf_r          <= req_r.is_signed && (req_r.dividend == MIN_NEG) &&
                                  (req_r.divisor == {WIDTH{1'b1}});
            end
        end
    end

    // Divider Start level: raised leaving PREP, held through FIN until the result is taken.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            div_start_r <= 1'b0;
        end else if (load_s && (req_r.divisor != {WIDTH{1'b0}})) begin
            div_start_r <= 1'b1;
        end else if (wr_div_s) begin
            div_start_r <= 1'b0;
        end else begin
            div_start_r <= div_start_r;
        end
    end

    // Response slot: a write may coincide with the consume of the previous result.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid_r     <= 1'b0;
            rsp_quotient_r  <= {WIDTH{1'b0}};
            rsp_remainder_r <= {WIDTH{1'b0}};
            rsp_dbz_r       <= 1'b0;
            rsp_ovf_r       <= 1'b0;
        end else if (wr_div_s) begin
            rsp_valid_r     <= 1'b1;
            rsp_quotient_r  <= cond_negate(DivQuotient, q_neg_r);
            rsp_remainder_r <= cond_negate(DivRemainder, r_neg_r);
            rsp_dbz_r       <= 1'b0;
            rsp_ovf_r       <= ovf_r;
        end else if (wr_dbz_s) begin
            rsp_valid_r     <= 1'b1;
            rsp_quotient_r  <= DBZ_QUOTIENT;
            rsp_remainder_r <= req_r.dividend;
            rsp_dbz_r       <= 1'b1;
            rsp_ovf_r       <= 1'b0;
        end else if (rsp_valid_r && RspReady) begin
            rsp_valid_r <= 1'b0;
        end else begin
            rsp_valid_r <= rsp_valid_r;
        end
    end

    assign DivStart     = div_start_r;
    assign DivDividend  = div_dividend_r;
    assign DivDivisor   = div_divisor_r;
    assign RspValid     = rsp_valid_r;
    assign RspQuotient  = rsp_quotient_r;
    assign RspRemainder = rsp_remainder_r;
    assign RspDivByZero = rsp_dbz_r;
    assign RspOverflow  = rsp_ovf_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: behavioural divider with lingering Done, table vectors,
// and a response scoreboard fed at request acceptance.
module tb_div_seq_ctrl;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        ReqValid = 1'b0, ReqReady, ReqSigned = 1'b0;
    logic [15:0] ReqDividend = 16'd0, ReqDivisor = 16'd0;
    logic        DivStart, DivDone;
    logic [15:0] DivDividend, DivDivisor, DivQuotient, DivRemainder;
    logic        RspValid, RspReady = 1'b0;
    logic [15:0] RspQuotient, RspRemainder;
    logic        RspDivByZero, RspOverflow;

    always #5 Clock = ~Clock;

    div_seq_ctrl #(.DEPTH(4), .WIDTH(16)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqSigned(ReqSigned),
        .ReqDividend(ReqDividend), .ReqDivisor(ReqDivisor),
        .DivStart(DivStart), .DivDividend(DivDividend), .DivDivisor(DivDivisor),
        .DivQuotient(DivQuotient), .DivRemainder(DivRemainder), .DivDone(DivDone),
        .RspValid(RspValid), .RspReady(RspReady),
        .RspQuotient(RspQuotient), .RspRemainder(RspRemainder),
        .RspDivByZero(RspDivByZero), .RspOverflow(RspOverflow)
    );

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        exp_t        e;
        logic [15:0] ma;
        logic [15:0] mb;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_rises = 0;
    int   n_rsp = 0;
    logic [15:0] rise_a, rise_b;
    logic        start_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division, truncating toward zero for signed operands.
    function automatic exp_t model(input logic s, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int   sa, sbv, qi, ri;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (b == 16'd0) begin
            e.q = 16'hFFFF; e.r = a; e.dbz = 1'b1;
        end else if (!s) begin
            e.q = a / b; e.r = a % b;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
            e.q = 16'h8000; e.r = 16'd0; e.ovf = 1'b1;
        end else begin
            sa = $signed(a); sbv = $signed(b);
            qi = sa / sbv; ri = sa % sbv;
            e.q = 16'(qi); e.r = 16'(ri);
        end
        return e;
    endfunction

    // Behavioural divider: 16 busy cycles, Done held while Start, then one lingering cycle.
    typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE, D_LINGER} dstate_t;
    dstate_t     ds;
    logic [3:0]  cnt;
    logic [15:0] lat_a, lat_b;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ds <= D_IDLE; DivDone <= 1'b0; DivQuotient <= 16'd0; DivRemainder <= 16'd0;
            cnt <= 4'd0; lat_a <= 16'd0; lat_b <= 16'd0;
        end else begin
            case (ds)
                D_IDLE: if (DivStart) begin
                    ds <= D_BUSY; cnt <= 4'd0; lat_a <= DivDividend; lat_b <= DivDivisor;
                end
                D_BUSY: if (cnt == 4'd15) begin
                    ds <= D_DONE; DivDone <= 1'b1;
                    DivQuotient  <= (lat_b == 16'd0) ? 16'hFFFF : lat_a / lat_b;
                    DivRemainder <= (lat_b == 16'd0) ? lat_a : lat_a % lat_b;
                end else begin
                    cnt <= cnt + 4'd1;
                end
                D_DONE: if (!DivStart) ds <= D_LINGER;
                D_LINGER: begin ds <= D_IDLE; DivDone <= 1'b0; end
                default: ds <= D_IDLE;
            endcase
        end
    end

    // Operand stability, Start-rise and response monitors.
    always @(negedge Clock) begin
        exp_t e;
        if (!Reset_n) begin
            start_prev = 1'b0;
        end else begin
            if (ds == D_BUSY && cnt == 4'd15) begin
                check("div_dividend_stable", 32'(DivDividend), 32'(lat_a));
                check("div_divisor_stable", 32'(DivDivisor), 32'(lat_b));
            end
            if (DivStart && !start_prev) begin
                check("start_rise_done_low", 32'(DivDone), 32'd0);
                n_rises++;
                rise_a = DivDividend;
                rise_b = DivDivisor;
            end
            start_prev = DivStart;
            if (RspValid && RspReady) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rsp_unexpected: got Q=%0h R=%0h, expected no response", RspQuotient, RspRemainder);
                end else begin
                    e = sb.pop_front();
                    n_rsp++;
                    check("rsp_quotient", 32'(RspQuotient), 32'(e.q));
                    check("rsp_remainder", 32'(RspRemainder), 32'(e.r));
                    check("rsp_divbyzero", 32'(RspDivByZero), 32'(e.dbz));
                    check("rsp_overflow", 32'(RspOverflow), 32'(e.ovf));
                end
            end
        end
    end

    task automatic send(input logic s, input logic [15:0] a, input logic [15:0] b, input exp_t e);
        logic ok = 1'b0;
        ReqSigned = s; ReqDividend = a; ReqDivisor = b; ReqValid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge Clock);
            if (ReqReady) begin ok = 1'b1; break; end
        end
        check("req_accept_in_time", 32'(ok), 32'd1);
        if (ok) begin
            @(posedge Clock);
            sb.push_back(e);
            #1;
        end
        ReqValid = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge Clock);
            if (sb.size() == 0) break;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    vec_t vecs[8];
    exp_t bp_e;
    int   rises0, rsp0, cyc;

    initial begin
        vecs[0] = '{1'b0, 16'd100,   16'd7,      '{16'd14,   16'd2,    1'b0, 1'b0}, 16'd100,   16'd7};
        vecs[1] = '{1'b1, 16'hFF9C,  16'd7,      '{16'hFFF2, 16'hFFFE, 1'b0, 1'b0}, 16'd100,   16'd7};
        vecs[2] = '{1'b1, 16'd100,   16'hFFF9,   '{16'hFFF2, 16'd2,    1'b0, 1'b0}, 16'd100,   16'd7};
        vecs[3] = '{1'b0, 16'd1234,  16'd0,      '{16'hFFFF, 16'd1234, 1'b1, 1'b0}, 16'd0,     16'd0};
        vecs[4] = '{1'b1, 16'h8000,  16'hFFFF,   '{16'h8000, 16'd0,    1'b0, 1'b1}, 16'h8000,  16'd1};
        vecs[5] = '{1'b0, 16'hFFFF,  16'd1,      '{16'hFFFF, 16'd0,    1'b0, 1'b0}, 16'hFFFF,  16'd1};
        vecs[6] = '{1'b1, 16'hFF9C,  16'hFFF9,   '{16'd14,   16'hFFFE, 1'b0, 1'b0}, 16'd100,   16'd7};
        vecs[7] = '{1'b1, 16'hFFFB,  16'd0,      '{16'hFFFF, 16'hFFFB, 1'b1, 1'b0}, 16'd0,     16'd0};

        repeat (3) @(posedge Clock);
        #1;
        check("reset_reqready", 32'(ReqReady), 32'd1);
        check("reset_divstart", 32'(DivStart), 32'd0);
        check("reset_divdividend", 32'(DivDividend), 32'd0);
        check("reset_divdivisor", 32'(DivDivisor), 32'd0);
        check("reset_rspvalid", 32'(RspValid), 32'd0);
        check("reset_rspquotient", 32'(RspQuotient), 32'd0);
        check("reset_rspremainder", 32'(RspRemainder), 32'd0);
        check("reset_flags", 32'({RspDivByZero, RspOverflow}), 32'd0);
        @(negedge Clock);
        Reset_n = 1'b1;
        RspReady = 1'b1;
        repeat (2) @(posedge Clock);
        #1;

        for (int i = 0; i < 8; i++) begin
            rises0 = n_rises;
            send(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].e);
            if (i == 0) begin
                cyc = 0;
                for (int k = 0; k < 40; k++) begin
                    @(posedge Clock); cyc++; #1;
                    if (RspValid) break;
                end
                check("latency_20_to_24", 32'((cyc >= 20) && (cyc <= 24)), 32'd1);
            end
            wait_drain("vector_response", 200);
            check("start_high_periods", 32'(n_rises - rises0), vecs[i].e.dbz ? 32'd0 : 32'd1);
            if (!vecs[i].e.dbz) begin
                check("div_dividend_magnitude", 32'(rise_a), 32'(vecs[i].ma));
                check("div_divisor_magnitude", 32'(rise_b), 32'(vecs[i].mb));
            end
            repeat (4) @(posedge Clock);
            #1;
        end

        // Back-pressure: consumer stalled, queue fills, then everything drains in order.
        RspReady = 1'b0;
        rsp0 = n_rsp;
        send(1'b0, 16'd1000,  16'd3,    model(1'b0, 16'd1000,  16'd3));
        send(1'b1, 16'hFC18,  16'd3,    model(1'b1, 16'hFC18,  16'd3));
        send(1'b0, 16'd77,    16'd0,    model(1'b0, 16'd77,    16'd0));
        send(1'b1, 16'h7FFF,  16'hFFFF, model(1'b1, 16'h7FFF,  16'hFFFF));
        send(1'b0, 16'd65535, 16'd255,  model(1'b0, 16'd65535, 16'd255));
        @(negedge Clock);
        check("bp_reqready_full", 32'(ReqReady), 32'd0);
        bp_e = model(1'b1, 16'h8000, 16'd2);
        send(1'b1, 16'h8000, 16'd2, bp_e);
        repeat (60) @(posedge Clock);
        #1;
        check("bp_rspvalid_held", 32'(RspValid), 32'd1);
        check("bp_reqready_full_again", 32'(ReqReady), 32'd0);
        check("bp_start_held_in_fin", 32'(DivStart), 32'd1);
        RspReady = 1'b1;
        wait_drain("bp_all_responses", 1000);
        check("bp_response_count", 32'(n_rsp - rsp0), 32'd6);
        repeat (4) @(posedge Clock);
        #1;

        // Reset in the middle of a division.
        send(1'b0, 16'd200, 16'd3, model(1'b0, 16'd200, 16'd3));
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (DivStart) break;
        end
        check("rst_reached_run", 32'(DivStart), 32'd1);
        repeat (5) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        check("rst_divstart_cleared", 32'(DivStart), 32'd0);
        check("rst_divdividend_cleared", 32'(DivDividend), 32'd0);
        check("rst_rspvalid_cleared", 32'(RspValid), 32'd0);
        check("rst_reqready", 32'(ReqReady), 32'd1);
        sb.delete();
        @(negedge Clock);
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        send(1'b0, 16'd50, 16'd5, '{16'd10, 16'd0, 1'b0, 1'b0});
        wait_drain("post_reset_response", 200);
        repeat (4) @(posedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
